aes_cipher_iter: RTL and testbench

Iterative AES encryption core that consumes the flat round-key bus produced by `key_expansion` and encrypts one 128-bit block per request, one round per clock. It sits directly downstream of `key_expansion`; `key_sched` connects straight to that block's `data_out`. A valid/ready handshake on both sides lets it drop into a streaming datapath.

---
 rtl/aes_pkg.sv | 29 ++
 rtl/aes_round.sv | 31 +++
 rtl/sbox.sv | 32 +++
 rtl/aes_cipher_iter.sv | 104 ++++++++++
 tb/tb_aes_cipher_iter.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES encryption core.
package aes_pkg;

    localparam int LEN_BLOCK = 128;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } aes_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // One state column, row 0 in the MSBs; 3*a is xtime(a)^a.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_round.sv
// Combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round
    import aes_pkg::*;
(
    input  logic [LEN_BLOCK-1:0] st_in,
    input  logic [LEN_BLOCK-1:0] rk,
    input  logic                 last,
    output logic [LEN_BLOCK-1:0] st_out
);

    logic [LEN_BLOCK-1:0] sub_bytes;
    logic [LEN_BLOCK-1:0] shifted;
    logic [LEN_BLOCK-1:0] mixed;

    sbox #(.NUM(16)) u_sbox (
        .din  (st_in),
        .dout (sub_bytes)
    );

    // Byte n sits at row n%4, column n/4; row r rotates left by r columns.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign shifted[127 - 8*(r + 4*c) -: 8] =
                sub_bytes[127 - 8*(r + 4*((c + r) % 4)) -: 8];
        end
        assign mixed[127 - 32*c -: 32] = mix_column(shifted[127 - 32*c -: 32]);
    end

    assign st_out = (last ? shifted : mixed) ^ rk;

endmodule

// File: rtl/sbox.sv
// Bank of NUM parallel AES forward S-boxes; byte i of din maps to byte i of dout.
module sbox #(
    parameter int NUM = 1
) (
    input  logic [NUM*8-1:0] din,
    output logic [NUM*8-1:0] dout
);

    localparam logic [0:255][7:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    for (genvar i = 0; i < NUM; i++) begin : g_lane
        assign dout[i*8 +: 8] = SBOX_TBL[din[i*8 +: 8]];
    end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryptor, one round per clock, valid/ready on both sides.
// Define AES_CIPHER_ITER_CNT_EN to add the 32-bit completed-block counter port blk_cnt.
module aes_cipher_iter
    import aes_pkg::*;
#(
    parameter int LEN_KEY   = 128,
    parameter int NUM_ROUND = 10
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [(NUM_ROUND+1)*LEN_BLOCK-1:0]   key_sched,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [LEN_BLOCK-1:0]                 in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [LEN_BLOCK-1:0]                 out_data
`ifdef AES_CIPHER_ITER_CNT_EN
    ,
    output logic [31:0]                          blk_cnt
`endif
);

    localparam int RW = $clog2(NUM_ROUND + 1);

    if (NUM_ROUND != LEN_KEY / 32 + 6) begin : g_cfg_check
        $error("aes_cipher_iter: NUM_ROUND does not match LEN_KEY");
    end

    aes_state_e           state_q;
    logic [RW-1:0]        rnd_q;
    logic [LEN_BLOCK-1:0] st_q;
    logic [LEN_BLOCK-1:0] rk_arr [NUM_ROUND+1];
    logic [LEN_BLOCK-1:0] rk_sel;
    logic [LEN_BLOCK-1:0] round_out;
    logic                 last_rnd;

    for (genvar r = 0; r <= NUM_ROUND; r++) begin : g_rk
        assign rk_arr[r] = key_sched[r*LEN_BLOCK +: LEN_BLOCK];
    end

    assign rk_sel   = rk_arr[rnd_q];
    assign last_rnd = (rnd_q == RW'(NUM_ROUND));

    aes_round u_round (
        .st_in  (st_q),
        .rk     (rk_sel),
        .last   (last_rnd),
        .st_out (round_out)
    );

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            // NOTE: the datapath register is cleared too, since out_data exposes it directly.
            st_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        st_q    <= in_data ^ rk_arr[0];
                        rnd_q   <= RW'(1);
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    st_q <= round_out;
                    if (last_rnd) begin
                        state_q <= DONE;
                    end else begin
                        rnd_q <= rnd_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = st_q;

`ifdef AES_CIPHER_ITER_CNT_EN
    logic [31:0] blk_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt_q <= '0;
        end else if (out_valid && out_ready) begin
            blk_cnt_q <= blk_cnt_q + 32'd1;
        end
    end

    assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Self-checking bench for aes_cipher_iter: FIPS-197 vectors for all key sizes plus
// randomized blocks against a reference model with its own S-box and key expansion.
module tb_aes_cipher_iter;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic [127:0] in_data;
    logic out_ready;

    logic [11*128-1:0] ks10;
    logic [13*128-1:0] ks12;
    logic [15*128-1:0] ks14;
    logic ir10, ov10, ir12, ov12, ir14, ov14;
    logic [127:0] od10, od12, od14;
`ifdef AES_CIPHER_ITER_CNT_EN
    logic [31:0] cnt10, cnt12, cnt14;
`endif

    always #5 clk = ~clk;

    aes_cipher_iter #(.LEN_KEY(128), .NUM_ROUND(10)) dut10 (
        .clk(clk), .rst(rst), .key_sched(ks10), .in_valid(in_valid), .in_ready(ir10),
        .in_data(in_data), .out_valid(ov10), .out_ready(out_ready), .out_data(od10)
`ifdef AES_CIPHER_ITER_CNT_EN
        , .blk_cnt(cnt10)
`endif
    );

    aes_cipher_iter #(.LEN_KEY(192), .NUM_ROUND(12)) dut12 (
        .clk(clk), .rst(rst), .key_sched(ks12), .in_valid(in_valid), .in_ready(ir12),
        .in_data(in_data), .out_valid(ov12), .out_ready(out_ready), .out_data(od12)
`ifdef AES_CIPHER_ITER_CNT_EN
        , .blk_cnt(cnt12)
`endif
    );

    aes_cipher_iter #(.LEN_KEY(256), .NUM_ROUND(14)) dut14 (
        .clk(clk), .rst(rst), .key_sched(ks14), .in_valid(in_valid), .in_ready(ir14),
        .in_data(in_data), .out_valid(ov14), .out_ready(out_ready), .out_data(od14)
`ifdef AES_CIPHER_ITER_CNT_EN
        , .blk_cnt(cnt14)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0] sb [256];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference model: plain GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] aa;
        logic [7:0] p;
        aa = {1'b0, a};
        p  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa[7:0];
            aa = aa << 1;
            if (aa[8]) aa = aa ^ 9'h11B;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x};
        return d[15 - n -: 8];
    endfunction

    // S-box from its definition: multiplicative inverse then the affine map.
    function automatic void build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    // Key is left-aligned in 256 bits; round r lands at [r*128 +: 128], word 4r in the MSBs.
    function automatic logic [1919:0] expand(input logic [255:0] key, input int nr);
        logic [31:0]   w [60];
        logic [31:0]   tmp;
        logic [7:0]    rc;
        logic [1919:0] ks;
        int nk;
        nk = nr - 6;
        rc = 8'h01;
        ks = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int r = 0; r <= nr; r++) ks[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ks;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1919:0] ks,
                                             input int nr);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ ks[127 - 8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[row + 4*c] = t[row + 4*((c + row) % 4)];
            if (r < nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
                    s[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[r*128 + 127 - 8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    // Waits for in_ready, hands one block to dut10 and waits (bounded) for its out_valid.
    task automatic run10(input logic [127:0] pt, input bit consume,
                         output logic [127:0] ct, output int lat);
        int w;
        w = 0;
        while (!ir10 && w < 40) begin @(negedge clk); w++; end
        in_data  = pt;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!ov10 && lat < 40) begin @(negedge clk); lat++; end
        ct = od10;
        if (consume) @(negedge clk);
    endtask

    function automatic logic [255:0] rand_key128();
        return {$urandom, $urandom, $urandom, $urandom, 128'h0};
    endfunction

    function automatic logic [127:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [127:0] PT_KAT = 128'h00112233445566778899aabbccddeeff;

    logic [1919:0] sched;
    logic [127:0]  pt, ct, exp_ct, blk [2], exp_blk [2];
    logic [127:0]  d10, d12, d14;
    int lat, lat10, lat12, lat14, na;
    int acc [2];
    logic [127:0] got [$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        build_sbox();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        sched = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 10);
        ks10  = sched[11*128-1:0];
        sched = expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 12);
        ks12  = sched[13*128-1:0];
        sched = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 14);
        ks14  = sched[15*128-1:0];

        repeat (2) @(negedge clk);
        check("reset_in_ready", 128'(ir10), 128'd1);
        check("reset_out_valid", 128'(ov10), 128'd0);
        check("reset_out_data", od10, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // All three key sizes at once; each finishes at its own round count.
        in_data = PT_KAT; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat10 = -1; lat12 = -1; lat14 = -1;
        d10 = '0; d12 = '0; d14 = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (ov10 && lat10 < 0) begin lat10 = c; d10 = od10; end
            if (ov12 && lat12 < 0) begin lat12 = c; d12 = od12; end
            if (ov14 && lat14 < 0) begin lat14 = c; d14 = od14; end
        end
        check("kat128_latency", 128'(lat10), 128'd10);
        check("kat128_data", d10, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        check("kat192_latency", 128'(lat12), 128'd12);
        check("kat192_data", d12, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
        check("kat256_latency", 128'(lat14), 128'd14);
        check("kat256_data", d14, 128'h8ea2b7ca516745bfeafc49904b496089);

        for (int k = 0; k < 4; k++) begin
            sched = expand(rand_key128(), 10);
            ks10  = sched[11*128-1:0];
            pt    = rand_block();
            run10(pt, 1'b1, ct, lat);
            check("rand_data", ct, encrypt(pt, sched, 10));
            check("rand_latency", 128'(lat), 128'd10);
        end

        // Backpressure: result must be held with in_ready low until out_ready.
        out_ready = 1'b0;
        pt = rand_block();
        exp_ct = encrypt(pt, sched, 10);
        run10(pt, 1'b0, ct, lat);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_data", od10, exp_ct);
            check("bp_out_valid", 128'(ov10), 128'd1);
            check("bp_in_ready", 128'(ir10), 128'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", 128'(ov10), 128'd0);
        check("bp_release_in_ready", 128'(ir10), 128'd1);
        @(negedge clk);
        check("bp_single_handshake", 128'(ov10), 128'd0);

        // Back-to-back with in_valid held and out_ready high.
        blk[0] = rand_block(); blk[1] = rand_block();
        exp_blk[0] = encrypt(blk[0], sched, 10);
        exp_blk[1] = encrypt(blk[1], sched, 10);
        got.delete();
        na = 0; acc[0] = 0; acc[1] = 0;
        in_valid = 1'b1; in_data = blk[0];
        for (int cyc = 0; cyc < 60 && got.size() < 2; cyc++) begin
            if (cyc > 0) begin
                in_valid = (na < 2);
                if (na < 2) in_data = blk[na];
            end
            if (in_valid && ir10 && na < 2) begin acc[na] = cyc; na++; end
            if (ov10) got.push_back(od10);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("b2b_accept_count", 128'(na), 128'd2);
        check("b2b_accept_spacing", 128'(acc[1] - acc[0]), 128'd12);
        check("b2b_result_count", 128'(got.size()), 128'd2);
        while (got.size() < 2) got.push_back('0);
        check("b2b_data0", got[0], exp_blk[0]);
        check("b2b_data1", got[1], exp_blk[1]);

        // Reset in the middle of round processing.
        repeat (3) @(negedge clk);
        in_data = rand_block(); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", 128'(ir10), 128'd1);
        check("midrst_out_valid", 128'(ov10), 128'd0);
        check("midrst_out_data", od10, 128'd0);
        pt = rand_block();
        run10(pt, 1'b1, ct, lat);
        check("midrst_fresh_data", ct, encrypt(pt, sched, 10));
        check("midrst_fresh_latency", 128'(lat), 128'd10);

`ifdef AES_CIPHER_ITER_CNT_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("cnt_reset", 128'(cnt10), 128'd0);
        for (int k = 0; k < 3; k++) begin
            pt = rand_block();
            run10(pt, 1'b1, ct, lat);
            check("cnt_block_data", ct, encrypt(pt, sched, 10));
        end
        check("cnt_three", 128'(cnt10), 128'd3);
        force dut10.blk_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut10.blk_cnt_q;
        check("cnt_forced", 128'(cnt10), 128'hFFFF_FFFF);
        pt = rand_block();
        run10(pt, 1'b1, ct, lat);
        check("cnt_wrap", 128'(cnt10), 128'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
